// File: rtl/hack_alu_pipe.sv
// hack_alu_pipe: two-stage pipelined Hack ALU with valid/ready handshakes.
//
// The six-bit Hack control code {zx,nx,zy,ny,f,no} is decoded in stage 1, which
// registers the conditioned operands x' and y'. Stage 2 computes the result and the
// zr/ng/cy/ov flags. A sideband tag travels with each operation.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands and control code present
//   in_ready   block can accept this cycle
//   a, b       x and y operands (WIDTH bits)
//   ctl        {zx,nx,zy,ny,f,no}
//   in_tag     sideband tag, returned unchanged with the result
//   out_valid  result and flags valid
//   out_ready  consumer accepts
//   out        result
//   out_tag    tag of this result
//   zr, ng     result is zero / result is negative
//   cy, ov     carry out / signed overflow of the x'+y' adder (0 when f=0)
module hack_alu_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       ctl,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [TAG_W-1:0] out_tag,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic             ov
);

    // Stage 1 state
    logic             v1_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             f_q;
    logic             no_q;
    logic [TAG_W-1:0] tag1_q;

    // Stage 2 state
    logic             v2_q;
    logic [WIDTH-1:0] out_q;
    logic [TAG_W-1:0] tag2_q;
    logic             zr_q;
    logic             ng_q;
    logic             cy_q;
    logic             ov_q;

    // Flow control and next-state values
    logic             adv1;
    logic             adv2;
    logic             ld1;
    logic             ld2;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r_d;
    logic             cy_d;
    logic             ov_d;

    // A stage may advance when its downstream slot is empty or emptying this cycle.
    always_comb begin
        adv2 = ~v2_q | out_ready;
        adv1 = ~v1_q | adv2;
        ld1  = adv1 & in_valid;
        ld2  = adv2 & v1_q;
    end

    // Stage 1: zero then optionally invert each operand.
    always_comb begin
        x_d = ctl[5] ? '0 : a;
        if (ctl[4]) begin
            x_d = ~x_d;
        end
        y_d = ctl[3] ? '0 : b;
        if (ctl[2]) begin
            y_d = ~y_d;
        end
    end

    // Stage 2: add or AND, then optional output inversion. Carry and overflow describe
    // the adder only, so they are taken before the inversion and masked by f.
    always_comb begin
        sum  = {1'b0, x_q} + {1'b0, y_q};
        r_d  = f_q ? sum[WIDTH-1:0] : (x_q & y_q);
        if (no_q) begin
            r_d = ~r_d;
        end
        cy_d = f_q & sum[WIDTH];
        ov_d = f_q & (x_q[WIDTH-1] == y_q[WIDTH-1]) & (sum[WIDTH-1] != x_q[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            f_q    <= 1'b0;
            no_q   <= 1'b0;
            tag1_q <= '0;
            v2_q   <= 1'b0;
            out_q  <= '0;
            tag2_q <= '0;
            zr_q   <= 1'b0;
            ng_q   <= 1'b0;
            cy_q   <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            if (adv1) begin
                v1_q <= in_valid;
            end
            if (ld1) begin
                x_q    <= x_d;
                y_q    <= y_d;
                f_q    <= ctl[1];
                no_q   <= ctl[0];
                tag1_q <= in_tag;
            end
            if (adv2) begin
                v2_q <= v1_q;
            end
            if (ld2) begin
                out_q  <= r_d;
                tag2_q <= tag1_q;
                zr_q   <= (r_d == '0);
                ng_q   <= r_d[WIDTH-1];
                cy_q   <= cy_d;
                ov_q   <= ov_d;
            end
        end
    end

    assign in_ready  = adv1;
    assign out_valid = v2_q;
    assign out       = out_q;
    assign out_tag   = tag2_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign cy        = cy_q;
    assign ov        = ov_q;

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Testbench for hack_alu_pipe (WIDTH=16, TAG_W=4): directed cases plus randomized
// traffic scored against an arithmetic reference model.
module tb_hack_alu_pipe;

    typedef struct packed {
        logic [15:0] r;
        logic [3:0]  tag;
        logic        zr;
        logic        ng;
        logic        cy;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [5:0]  ctl = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out;
    logic [3:0]  out_tag;
    logic        zr;
    logic        ng;
    logic        cy;
    logic        ov;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic        acc;
    logic        ir_seen;
    logic        ov_seen;
    logic        hold_q = 1'b0;
    logic [31:0] snap;
    logic        use_dir = 1'b0;
    exp_t        dir_e;

    hack_alu_pipe #(
        .WIDTH(16),
        .TAG_W(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .ctl      (ctl),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .out_tag  (out_tag),
        .zr       (zr),
        .ng       (ng),
        .cy       (cy),
        .ov       (ov)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Reference: Hack semantics using unsigned/signed integer arithmetic.
    function automatic exp_t model(input logic [15:0] pa, input logic [15:0] pb,
                                   input logic [5:0] c, input logic [3:0] t);
        int   x, y, s, r, sx, sy;
        exp_t e;
        x = c[5] ? 0 : int'(pa);
        if (c[4]) x = 65535 - x;
        y = c[3] ? 0 : int'(pb);
        if (c[2]) y = 65535 - y;
        s = x + y;
        r = c[1] ? (s % 65536) : (x & y);
        if (c[0]) r = 65535 - r;
        sx = (x >= 32768) ? x - 65536 : x;
        sy = (y >= 32768) ? y - 65536 : y;
        e.r   = r[15:0];
        e.tag = t;
        e.zr  = (r == 0);
        e.ng  = (r >= 32768);
        e.cy  = c[1] && (s >= 65536);
        e.ov  = c[1] && ((sx + sy > 32767) || (sx + sy < -32768));
        return e;
    endfunction

    // One clock: observe at negedge, score, then advance past the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        ir_seen = in_ready;
        ov_seen = out_valid;
        acc     = in_valid && in_ready && !rst;
        if (!rst) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !(sb.size() == 2 && !out_ready)});
            if (hold_q) chk("hold", {7'd0, out_valid, out, out_tag, zr, ng, cy, ov}, snap);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out", {16'd0, out}, {16'd0, e.r});
                    chk("tag", {28'd0, out_tag}, {28'd0, e.tag});
                    chk("flags", {28'd0, zr, ng, cy, ov}, {28'd0, e.zr, e.ng, e.cy, e.ov});
                end
            end
            hold_q = out_valid && !out_ready;
            snap   = {7'd0, out_valid, out, out_tag, zr, ng, cy, ov};
            if (acc) sb.push_back(use_dir ? dir_e : model(a, b, ctl, in_tag));
        end else begin
            sb.delete();
            hold_q = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dir_op(input logic [15:0] pa, input logic [15:0] pb, input logic [5:0] c,
                          input logic [15:0] r, input logic [3:0] f4);
        int n = 0;
        a = pa; b = pb; ctl = c; in_tag = in_tag + 4'd1;
        dir_e = '{r: r, tag: in_tag, zr: f4[3], ng: f4[2], cy: f4[1], ov: f4[0]};
        use_dir  = 1'b1;
        in_valid = 1'b1;
        do begin
            step();
            n++;
        end while (!acc && n < 10);
        if (!acc) chk("accept", 32'd0, 32'd1);
        in_valid = 1'b0;
        use_dir  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {12'd0, out, out_tag}, 32'd0);
        chk("rst_flags", {28'd0, zr, ng, cy, ov}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 1: add with exact latency; flags {zr,ng,cy,ov}
        out_ready = 1'b1;
        dir_op(16'd5, 16'd3, 6'b000010, 16'd8, 4'b0000);
        step();
        chk("lat_n+1", {31'd0, ov_seen}, 32'd0);
        step();
        chk("lat_n+2", {31'd0, ov_seen}, 32'd1);
        drain();

        // 2-4: subtraction, overflow/carry, constants
        dir_op(16'd3, 16'd5, 6'b010011, 16'hFFFE, 4'b0110);
        dir_op(16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 4'b0101);
        dir_op(16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 4'b1010);
        dir_op(16'h1234, 16'hBEEF, 6'b101010, 16'h0000, 4'b1000);
        dir_op(16'hA5A5, 16'h5A5A, 6'b111111, 16'h0001, 4'b0010);
        dir_op(16'h0F0F, 16'hCAFE, 6'b111010, 16'hFFFF, 4'b0100);
        drain();

        // 5: backpressure with tags 0..3
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); ctl = 6'($urandom); in_tag = 4'(i);
            step();
            if (i < 2) chk("bp_accept", {31'd0, acc}, 32'd1);
        end
        chk("bp_in_ready_low", {31'd0, ir_seen}, 32'd0);
        chk("bp_out_valid", {31'd0, ov_seen}, 32'd1);
        step();
        step();
        out_ready = 1'b1;
        for (int i = 2, n = 0; i < 4 && n < 10; n++) begin
            a = 16'($urandom); b = 16'($urandom); ctl = 6'($urandom); in_tag = 4'(i);
            step();
            if (acc) i++;
        end
        drain();

        // 6: reset with two operations in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a = 16'($urandom); b = 16'($urandom); ctl = 6'($urandom); in_tag = 4'(8 + i);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out", {12'd0, out, out_tag}, 32'd0);
        chk("mid_rst_flags", {28'd0, zr, ng, cy, ov}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_stale", {31'd0, ov_seen}, 32'd0);
        end

        // Randomized traffic with random stalls
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom); ctl = 6'($urandom); in_tag = 4'($urandom);
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
